adma_atx_wrr_sched: RTL and testbench

ADMA_ATX_WRR_SCHED -- requirements
Module: adma_atx_wrr_sched

---
 rtl/adma_pkg.sv | 33 +++
 rtl/adma_rr_pick.sv | 38 +++
 rtl/adma_atx_wrr_sched.sv | 182 ++++++++++++++++++
 tb/tb_adma_atx_wrr_sched.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adma_pkg.sv
// Shared types for the ADMA AXI transaction scheduler: the packed AR/AW
// descriptor layout and the per-decision arbitration state.
package adma_pkg;

    localparam int ATX_ID_W    = 4;
    localparam int ATX_ADDR_W  = 32;
    localparam int ATX_LEN_W   = 4;
    localparam int ATX_BURST_W = 2;

    // One AXI address-channel request (AR or AW).
    typedef struct packed {
        logic [ATX_ID_W-1:0]    id;
        logic [ATX_ADDR_W-1:0]  addr;
        logic [ATX_LEN_W-1:0]   len;
        logic [ATX_BURST_W-1:0] burst;
    } atx_chan_t;

    // Full per-channel descriptor: read side followed by write side.
    typedef struct packed {
        atx_chan_t ar;
        atx_chan_t aw;
    } atx_desc_t;

    localparam int ATX_DESC_W = $bits(atx_desc_t);

    // HOLD: the current channel keeps priority for this grant.
    // ADVANCE: priority moves to the next valid channel.
    typedef enum logic {
        ARB_HOLD    = 1'b0,
        ARB_ADVANCE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/adma_rr_pick.sv
// Combinational first-valid search starting at start_i and wrapping at N-1.
module adma_rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vld_i,
    input  logic [W-1:0] start_i,
    output logic [W-1:0] winner_o,
    output logic         any_vld_o
);

    int         idx_int;
    logic [W-1:0] idx_s;

    // Walk start_i, start_i+1, ... modulo N and keep the first valid index
    always_comb begin
        winner_o  = start_i;
        any_vld_o = 1'b0;
        idx_int   = 0;
        idx_s     = start_i;
        for (int i = 0; i < N; i++) begin
            idx_int = int'(start_i) + i;
            if (idx_int >= N) begin
                idx_int = idx_int - N;
            end else begin
                idx_int = idx_int;
            end
            idx_s = W'(idx_int);
            if (!any_vld_o && vld_i[idx_s]) begin
                winner_o  = idx_s;
                any_vld_o = 1'b1;
            end else begin
                any_vld_o = any_vld_o;
            end
        end
    end

endmodule

// File: rtl/adma_atx_wrr_sched.sv
// Weighted round-robin scheduler forwarding per-channel AXI descriptors
// through a single output register slice with an outstanding-count limit.
// Build option: ADMA_ATX_WRR_EN selects weighted turns (credit per channel
// turn bounded by chn_arb_rate); when undefined, plain round-robin.
module adma_atx_wrr_sched
    import adma_pkg::*;
#(
    parameter int DMA_CHN_NUM   = 4,
    parameter int DMA_CHN_ARB_W = 3,
    parameter int ATX_INFO_W    = 84,
    parameter int MAX_OUTST     = 4,
    parameter int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [ATX_INFO_W-1:0]                     req_info [0:DMA_CHN_NUM-1],
    input  logic [DMA_CHN_NUM-1:0]                    req_vld,
    output logic [DMA_CHN_NUM-1:0]                    req_rdy,
    input  logic [DMA_CHN_NUM-1:0][DMA_CHN_ARB_W-1:0] chn_arb_rate,
    output logic [DMA_CHN_NUM_W-1:0]                  fwd_chn_id,
    output logic [ATX_INFO_W-1:0]                     fwd_info,
    output logic                                      fwd_vld,
    input  logic                                      fwd_rdy,
    input  logic                                      atx_done,
    output logic [7:0]                                outst_cnt
);

    localparam logic [DMA_CHN_NUM_W-1:0] LAST_CHN    = DMA_CHN_NUM_W'(DMA_CHN_NUM - 1);
    localparam logic [7:0]               OUTST_LIMIT = 8'(MAX_OUTST);

    // Next channel index with wrap, valid for non-power-of-two counts.
    function automatic logic [DMA_CHN_NUM_W-1:0] chn_inc(input logic [DMA_CHN_NUM_W-1:0] c);
        chn_inc = (c == LAST_CHN) ? {DMA_CHN_NUM_W{1'b0}} : c + DMA_CHN_NUM_W'(1'b1);
    endfunction

    logic                     run_q;
    logic [DMA_CHN_NUM_W-1:0] cur_chn_q, cur_chn_d;
    logic                     fwd_vld_q;
    logic [ATX_INFO_W-1:0]    fwd_info_q;
    logic [DMA_CHN_NUM_W-1:0] fwd_chn_q;
    logic [7:0]               outst_q, outst_d;
    logic [DMA_CHN_NUM_W-1:0] start_s, pick_s, winner_s;
    logic                     any_vld_s, slot_free_s, grant_s, done_eff_s;

    adma_rr_pick #(
        .N (DMA_CHN_NUM),
        .W (DMA_CHN_NUM_W)
    ) u_pick (
        .vld_i     (req_vld),
        .start_i   (start_s),
        .winner_o  (pick_s),
        .any_vld_o (any_vld_s)
    );

    // The slot can take a new descriptor when empty or draining this cycle;
    // run_q keeps the first edge after reset release grant-free.
    assign slot_free_s = !fwd_vld_q || fwd_rdy;
    assign grant_s     = run_q && slot_free_s && (outst_q < OUTST_LIMIT) && any_vld_s;
    assign done_eff_s  = atx_done && (outst_q != 8'd0);

`ifdef ADMA_ATX_WRR_EN
    logic [DMA_CHN_ARB_W-1:0] credit_q, credit_d, rate_s, eff_rate_s;
    arb_state_e               arb_st_s;

    // A programmed rate of 0 still allows one grant per turn.
    assign rate_s     = chn_arb_rate[cur_chn_q];
    assign eff_rate_s = (rate_s == {DMA_CHN_ARB_W{1'b0}}) ? DMA_CHN_ARB_W'(1'b1) : rate_s;
    assign arb_st_s   = (req_vld[cur_chn_q] && (credit_q < eff_rate_s)) ? ARB_HOLD : ARB_ADVANCE;
    assign start_s    = chn_inc(cur_chn_q);
    assign winner_s   = (arb_st_s == ARB_HOLD) ? cur_chn_q : pick_s;

    // Turn bookkeeping: extend the current turn or hand it to the winner
    always_comb begin
        cur_chn_d = cur_chn_q;
        credit_d  = credit_q;
        if (grant_s) begin
            case (arb_st_s)
                ARB_HOLD: begin
                    if (credit_q != {DMA_CHN_ARB_W{1'b1}}) begin
                        credit_d = credit_q + DMA_CHN_ARB_W'(1'b1);
                    end else begin
                        credit_d = credit_q;
                    end
                end
                ARB_ADVANCE: begin
                    cur_chn_d = winner_s;
                    credit_d  = DMA_CHN_ARB_W'(1'b1);
                end
                default: begin
                    cur_chn_d = cur_chn_q;
                    credit_d  = credit_q;
                end
            endcase
        end else begin
            cur_chn_d = cur_chn_q;
            credit_d  = credit_q;
        end
    end

    // Credit counter for the channel owning the current turn
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= {DMA_CHN_ARB_W{1'b0}};
        end else begin
            credit_q <= credit_d;
        end
    end
`else
    logic unused_rate_s;

    // Plain round-robin: cur_chn is the search start, moved past each winner.
    assign unused_rate_s = ^chn_arb_rate;
    assign start_s       = cur_chn_q;
    assign winner_s      = pick_s;

    // Search pointer advances to the channel after the last winner
    always_comb begin
        cur_chn_d = cur_chn_q;
        if (grant_s) begin
            cur_chn_d = chn_inc(winner_s);
        end else begin
            cur_chn_d = cur_chn_q;
        end
    end
`endif

    // One-hot accept toward the granted channel
    always_comb begin
        req_rdy = {DMA_CHN_NUM{1'b0}};
        if (grant_s) begin
            req_rdy[winner_s] = 1'b1;
        end else begin
            req_rdy = {DMA_CHN_NUM{1'b0}};
        end
    end

    // Outstanding count: grant and completion in the same cycle cancel out
    always_comb begin
        outst_d = outst_q;
        case ({grant_s, done_eff_s})
            2'b10:   outst_d = outst_q + 8'd1;
            2'b01:   outst_d = outst_q - 8'd1;
            default: outst_d = outst_q;
        endcase
    end

    // Arbitration pointer, outstanding count and post-reset grant enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            cur_chn_q <= {DMA_CHN_NUM_W{1'b0}};
            outst_q   <= 8'd0;
        end else begin
            run_q     <= 1'b1;
            cur_chn_q <= cur_chn_d;
            outst_q   <= outst_d;
        end
    end

    // Output slice: load on grant, empty on accept, hold under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_vld_q  <= 1'b0;
            fwd_info_q <= {ATX_INFO_W{1'b0}};
            fwd_chn_q  <= {DMA_CHN_NUM_W{1'b0}};
        end else if (grant_s) begin
            fwd_vld_q  <= 1'b1;
            fwd_info_q <= req_info[winner_s];
            fwd_chn_q  <= winner_s;
        end else if (fwd_rdy) begin
            fwd_vld_q  <= 1'b0;
        end else begin
            fwd_vld_q  <= fwd_vld_q;
        end
    end

    assign fwd_vld    = fwd_vld_q;
    assign fwd_info   = fwd_info_q;
    assign fwd_chn_id = fwd_chn_q;
    assign outst_cnt  = outst_q;

endmodule

// File: tb/tb_adma_atx_wrr_sched.sv
// Directed self-checking bench for adma_atx_wrr_sched (4 channels,
// MAX_OUTST=4). Expected grant orders follow ADMA_ATX_WRR_EN.
module tb_adma_atx_wrr_sched;
    import adma_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [83:0]       req_info [0:3];
    logic [3:0]        req_vld;
    logic [3:0]        req_rdy;
    logic [3:0][2:0]   chn_arb_rate;
    logic [1:0]        fwd_chn_id;
    logic [83:0]       fwd_info;
    logic              fwd_vld;
    logic              fwd_rdy;
    logic              atx_done;
    logic [7:0]        outst_cnt;

    int checks   = 0;
    int failures = 0;

    adma_atx_wrr_sched #(
        .DMA_CHN_NUM   (4),
        .DMA_CHN_ARB_W (3),
        .ATX_INFO_W    (84),
        .MAX_OUTST     (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_info     (req_info),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .chn_arb_rate (chn_arb_rate),
        .fwd_chn_id   (fwd_chn_id),
        .fwd_info     (fwd_info),
        .fwd_vld      (fwd_vld),
        .fwd_rdy      (fwd_rdy),
        .atx_done     (atx_done),
        .outst_cnt    (outst_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        req_vld  = 4'b0000;
        atx_done = 1'b0;
        fwd_rdy  = 1'b1;
        rst_n    = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic init_info();
        atx_desc_t d;
        for (int c = 0; c < 4; c++) begin
            d          = '0;
            d.ar.id    = 4'(c);
            d.ar.addr  = 32'h4000_0000 | 32'(c << 8);
            d.ar.len   = 4'hF;
            d.ar.burst = 2'b01;
            d.aw.id    = 4'(c + 8);
            d.aw.addr  = 32'h8000_0000 | 32'(c);
            d.aw.len   = 4'(c);
            d.aw.burst = 2'b10;
            req_info[c] = d;
        end
    endtask

    task automatic test_reset();
        req_vld      = 4'b1111;
        chn_arb_rate = {3'd1, 3'd3, 3'd1, 3'd2};
        fwd_rdy      = 1'b1;
        atx_done     = 1'b0;
        rst_n        = 1'b0;
        #3;
        checks++; if (req_rdy !== 4'b0000) begin failures++; $display("FAIL reset_req_rdy got=%b exp=%b", req_rdy, 4'b0000); end
        checks++; if (fwd_vld !== 1'b0) begin failures++; $display("FAIL reset_fwd_vld got=%b exp=0", fwd_vld); end
        checks++; if (fwd_info !== 84'd0) begin failures++; $display("FAIL reset_fwd_info got=%h exp=0", fwd_info); end
        checks++; if (fwd_chn_id !== 2'd0) begin failures++; $display("FAIL reset_fwd_chn got=%0d exp=0", fwd_chn_id); end
        checks++; if (outst_cnt !== 8'd0) begin failures++; $display("FAIL reset_outst got=%0d exp=0", outst_cnt); end
        tick();
        req_vld = 4'b0000;
    endtask

    task automatic test_wrr_order();
        int exp_seq [10];
`ifdef ADMA_ATX_WRR_EN
        exp_seq = '{0, 0, 1, 2, 2, 2, 3, 0, 0, 1};
`else
        exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
`endif
        apply_reset();
        chn_arb_rate = {3'd1, 3'd3, 3'd1, 3'd2};
        req_vld  = 4'b1111;
        atx_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (req_rdy !== 4'(1 << exp_seq[i])) begin failures++; $display("FAIL order_rdy[%0d] got=%b exp_chn=%0d", i, req_rdy, exp_seq[i]); end
            tick();
            checks++; if (fwd_chn_id !== 2'(exp_seq[i]) || fwd_vld !== 1'b1) begin failures++; $display("FAIL order_chn[%0d] got=%0d vld=%b exp=%0d", i, fwd_chn_id, fwd_vld, exp_seq[i]); end
            checks++; if (fwd_info !== req_info[exp_seq[i]]) begin failures++; $display("FAIL order_info[%0d] got=%h exp=%h", i, fwd_info, req_info[exp_seq[i]]); end
        end
        checks++; if (outst_cnt !== 8'd1) begin failures++; $display("FAIL order_outst got=%0d exp=1", outst_cnt); end
        atx_done = 1'b0;
        req_vld  = 4'b0000;
    endtask

    task automatic test_single_rate0();
        apply_reset();
        chn_arb_rate = {3'd0, 3'd0, 3'd0, 3'd0};
        atx_done = 1'b1;
        #1;
        checks++; if (fwd_vld !== 1'b0) begin failures++; $display("FAIL single_idle_vld got=%b exp=0", fwd_vld); end
        req_vld = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (req_rdy !== 4'b0100) begin failures++; $display("FAIL single_rdy[%0d] got=%b exp=0100", i, req_rdy); end
            tick();
            checks++; if (fwd_vld !== 1'b1 || fwd_chn_id !== 2'd2 || fwd_info !== req_info[2]) begin failures++; $display("FAIL single_fwd[%0d] vld=%b chn=%0d exp vld=1 chn=2", i, fwd_vld, fwd_chn_id); end
        end
        atx_done = 1'b0;
        req_vld  = 4'b0000;
    endtask

    task automatic test_max_outst();
        int grants;
        apply_reset();
        chn_arb_rate = {3'd1, 3'd3, 3'd1, 3'd2};
        req_vld = 4'b1111;
        grants  = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (req_rdy !== 4'b0000) grants++;
            tick();
        end
        checks++; if (grants !== 4) begin failures++; $display("FAIL maxo_grants got=%0d exp=4", grants); end
        #1;
        checks++; if (outst_cnt !== 8'd4) begin failures++; $display("FAIL maxo_outst got=%0d exp=4", outst_cnt); end
        checks++; if (req_rdy !== 4'b0000) begin failures++; $display("FAIL maxo_rdy got=%b exp=0000", req_rdy); end
        atx_done = 1'b1;
        tick();
        atx_done = 1'b0;
        grants   = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (req_rdy !== 4'b0000) grants++;
            tick();
        end
        checks++; if (grants !== 1) begin failures++; $display("FAIL maxo_extra got=%0d exp=1", grants); end
        checks++; if (outst_cnt !== 8'd4) begin failures++; $display("FAIL maxo_outst2 got=%0d exp=4", outst_cnt); end
        req_vld = 4'b0000;
    endtask

    task automatic test_backpressure();
        logic [1:0] exp_next;
`ifdef ADMA_ATX_WRR_EN
        exp_next = 2'd0;
`else
        exp_next = 2'd1;
`endif
        apply_reset();
        chn_arb_rate = {3'd1, 3'd3, 3'd1, 3'd2};
        req_vld  = 4'b1111;
        atx_done = 1'b1;
        tick();
        fwd_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (req_rdy !== 4'b0000) begin failures++; $display("FAIL bp_rdy[%0d] got=%b exp=0000", i, req_rdy); end
            checks++; if (fwd_vld !== 1'b1 || fwd_info !== req_info[0] || fwd_chn_id !== 2'd0) begin failures++; $display("FAIL bp_hold[%0d] vld=%b chn=%0d info=%h", i, fwd_vld, fwd_chn_id, fwd_info); end
            tick();
        end
        fwd_rdy = 1'b1;
        #1;
        checks++; if (req_rdy !== 4'(1 << exp_next)) begin failures++; $display("FAIL bp_release_rdy got=%b exp_chn=%0d", req_rdy, exp_next); end
        tick();
        checks++; if (fwd_chn_id !== exp_next || fwd_info !== req_info[exp_next]) begin failures++; $display("FAIL bp_release_fwd got=%0d exp=%0d", fwd_chn_id, exp_next); end
        atx_done = 1'b0;
        req_vld  = 4'b0000;
    endtask

    task automatic test_outst_simul();
        apply_reset();
        req_vld = 4'b0001;
        repeat (3) tick();
        #1;
        checks++; if (outst_cnt !== 8'd3) begin failures++; $display("FAIL simul_pre got=%0d exp=3", outst_cnt); end
        checks++; if (req_rdy !== 4'b0001) begin failures++; $display("FAIL simul_rdy got=%b exp=0001", req_rdy); end
        atx_done = 1'b1;
        tick();
        checks++; if (outst_cnt !== 8'd3) begin failures++; $display("FAIL simul_both got=%0d exp=3", outst_cnt); end
        req_vld = 4'b0000;
        tick();
        checks++; if (outst_cnt !== 8'd2) begin failures++; $display("FAIL simul_dec got=%0d exp=2", outst_cnt); end
        repeat (2) tick();
        checks++; if (outst_cnt !== 8'd0) begin failures++; $display("FAIL simul_zero got=%0d exp=0", outst_cnt); end
        tick();
        checks++; if (outst_cnt !== 8'd0) begin failures++; $display("FAIL simul_underflow got=%0d exp=0", outst_cnt); end
        atx_done = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        chn_arb_rate = {3'd1, 3'd3, 3'd1, 3'd2};
        req_vld = 4'b1111;
        repeat (2) tick();
        fwd_rdy = 1'b0;
        #1;
        checks++; if (fwd_vld !== 1'b1 || outst_cnt !== 8'd2) begin failures++; $display("FAIL mid_pre vld=%b outst=%0d exp 1/2", fwd_vld, outst_cnt); end
        rst_n = 1'b0;
        #1;
        checks++; if (fwd_vld !== 1'b0 || outst_cnt !== 8'd0) begin failures++; $display("FAIL mid_async vld=%b outst=%0d exp 0/0", fwd_vld, outst_cnt); end
        checks++; if (req_rdy !== 4'b0000 || fwd_info !== 84'd0) begin failures++; $display("FAIL mid_clear rdy=%b info=%h", req_rdy, fwd_info); end
        tick();
        rst_n   = 1'b1;
        fwd_rdy = 1'b1;
        #1;
        checks++; if (req_rdy !== 4'b0000) begin failures++; $display("FAIL mid_first got=%b exp=0000", req_rdy); end
        tick();
        #1;
        checks++; if (req_rdy !== 4'b0001) begin failures++; $display("FAIL mid_restart_rdy got=%b exp=0001", req_rdy); end
        tick();
        checks++; if (fwd_vld !== 1'b1 || fwd_chn_id !== 2'd0) begin failures++; $display("FAIL mid_restart_fwd vld=%b chn=%0d exp 1/0", fwd_vld, fwd_chn_id); end
        req_vld = 4'b0000;
    endtask

    initial begin
        rst_n = 1'b0;
        init_info();
        test_reset();
        test_wrr_order();
        test_single_rate0();
        test_max_outst();
        test_backpressure();
        test_outst_simul();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
